demux_load_sequencer: RTL and testbench

//  Sequences a 1-to-NUM_LANES demux that fans one operand stream out to the rows/columns of the systolic array.

---
 rtl/demux_load_sequencer_if.sv | 38 +++
 rtl/demux_load_sequencer.sv | 124 ++++++++++++
 tb/tb_demux_load_sequencer.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/demux_load_sequencer_if.sv
// Stream and demux bus bundle for demux_load_sequencer.
// Carries the load command (start/num_words/abort) and the upstream
// valid/ready word stream into the sequencer. It also carries the demux drive
// (sel_out/data_out/lane_we) and the status pulses (busy/done/err) back out.
//   master : the side that issues commands and supplies words
//   slave  : the sequencer itself
interface demux_load_sequencer_if #(
    parameter int NUM_LANES    = 32,
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 16
);
    // command
    logic                           start;
    logic [SELECT_WIDTH:0]          num_words;
    logic                           abort;
    // upstream stream
    logic                           in_valid;
    logic signed [DATA_WIDTH-1:0]   in_data;
    logic                           in_ready;
    // demux drive
    logic [SELECT_WIDTH-1:0]        sel_out;
    logic signed [DATA_WIDTH-1:0]   data_out;
    logic [NUM_LANES-1:0]           lane_we;
    // status
    logic                           busy;
    logic                           done;
    logic                           err;

    modport master (
        output start, num_words, abort, in_valid, in_data,
        input  in_ready, sel_out, data_out, lane_we, busy, done, err
    );

    modport slave (
        input  start, num_words, abort, in_valid, in_data,
        output in_ready, sel_out, data_out, lane_we, busy, done, err
    );
endinterface

// File: rtl/demux_load_sequencer.sv
// demux_load_sequencer
// Sequences a 1-to-NUM_LANES demux that fans one operand stream out to the
// rows/columns of the systolic array. A load command latches a word count.
// Words are then pulled over a valid/ready stream and written lane by lane
// (lane 0 first) through sel_out/data_out/one-hot lane_we. done pulses in the
// cycle that carries the last write.
// Ports:
//   clk    : rising-edge clock
//   rst_n  : synchronous active-low reset
//   bus    : demux_load_sequencer_if.slave
//            start/num_words/abort : load command, cancel
//            in_valid/in_data/in_ready : upstream word stream
//            sel_out/data_out/lane_we : demux drive, registered
//            busy/done/err : status, registered
module demux_load_sequencer #(
    parameter int NUM_LANES    = 32,
    parameter int SELECT_WIDTH = 5,
    parameter int DATA_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    demux_load_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [SELECT_WIDTH:0]  MAX_WORDS = (SELECT_WIDTH+1)'(NUM_LANES);
    localparam logic [SELECT_WIDTH:0]  ONE_CNT   = (SELECT_WIDTH+1)'(1);
    localparam logic [NUM_LANES-1:0]   LANE0     = NUM_LANES'(1);

    state_t                          state;
    logic [SELECT_WIDTH-1:0]         idx;
    logic [SELECT_WIDTH:0]           cnt;

    logic [SELECT_WIDTH-1:0]         sel_q;
    logic signed [DATA_WIDTH-1:0]    data_q;
    logic [NUM_LANES-1:0]            we_q;
    logic                            busy_q;
    logic                            done_q;
    logic                            err_q;

    logic                            ready;
    logic                            accept;
    logic                            last_word;
    logic                            num_ok;

    // abort suppresses ready, so abort wins over a same-cycle handshake
    assign ready     = (state == LOAD) && !bus.abort;
    assign accept    = bus.in_valid && ready;
    assign last_word = ({1'b0, idx} == (cnt - ONE_CNT));
    assign num_ok    = (bus.num_words != '0) && (bus.num_words <= MAX_WORDS);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            idx    <= '0;
            cnt    <= '0;
            sel_q  <= '0;
            data_q <= '0;
            we_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            // strobes and pulses default low; sel/data hold so the demux
            // inputs stay stable between writes
            we_q   <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        if (num_ok) begin
                            cnt    <= bus.num_words;
                            idx    <= '0;
                            state  <= LOAD;
                            busy_q <= 1'b1;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (bus.abort) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (accept) begin
                        sel_q  <= idx;
                        data_q <= bus.in_data;
                        we_q   <= LANE0 << idx;
                        if (last_word) begin
                            // last write and done share the DONE cycle
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready = ready;
    assign bus.sel_out  = sel_q;
    assign bus.data_out = data_q;
    assign bus.lane_we  = we_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.err      = err_q;

endmodule

// File: tb/tb_demux_load_sequencer.sv
// Directed bench for demux_load_sequencer.
module tb_demux_load_sequencer;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    demux_load_sequencer_if #(.NUM_LANES(32), .SELECT_WIDTH(5), .DATA_WIDTH(16)) bus_if ();

    demux_load_sequencer #(
        .NUM_LANES(32),
        .SELECT_WIDTH(5),
        .DATA_WIDTH(16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_we"},   64'(bus_if.lane_we), 64'd0);
        chk({tag, "_busy"}, 64'(bus_if.busy),    64'd0);
        chk({tag, "_done"}, 64'(bus_if.done),    64'd0);
        chk({tag, "_err"},  64'(bus_if.err),     64'd0);
    endtask

    logic signed [15:0] d;
    int writes;
    int dones;
    logic [31:0] bp_valid;
    logic [31:0] bp_we  [7];
    logic [4:0]  bp_sel [7];
    logic [15:0] bp_data[7];
    logic        bp_done[7];

    initial begin
        bp_valid = 32'b1011001; // bit i = valid in LOAD cycle i
        bp_we    = '{32'h1, 32'h0, 32'h0, 32'h2, 32'h4, 32'h0, 32'h8};
        bp_sel   = '{5'd0, 5'd0, 5'd0, 5'd1, 5'd2, 5'd2, 5'd3};
        bp_data  = '{16'h1000, 16'h1000, 16'h1000, 16'h1003, 16'h1004, 16'h1004, 16'h1006};
        bp_done  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        rst_n            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.num_words = '0;
        bus_if.abort     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_data   = '0;
        tick();
        tick();
        chk_idle_outputs("rst0");
        chk("rst0_sel",   64'(bus_if.sel_out),  64'd0);
        chk("rst0_data",  64'(bus_if.data_out), 64'd0);
        chk("rst0_ready", 64'(bus_if.in_ready), 64'd0);
        rst_n = 1'b1;
        tick();

        // 1. reset in the middle of LOAD (idx=7)
        bus_if.start = 1'b1; bus_if.num_words = 6'd10;
        tick();
        bus_if.start = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            bus_if.in_data = 16'(k + 1);
            tick();
        end
        chk("pre_rst_sel", 64'(bus_if.sel_out), 64'd6);
        rst_n = 1'b0;
        tick();
        chk_idle_outputs("rst1");
        chk("rst1_sel",   64'(bus_if.sel_out),  64'd0);
        chk("rst1_data",  64'(bus_if.data_out), 64'd0);
        chk("rst1_ready", 64'(bus_if.in_ready), 64'd0);
        rst_n = 1'b1;
        tick();
        chk("rst1_ready_after", 64'(bus_if.in_ready), 64'd0);
        bus_if.in_valid = 1'b0;

        // 2. full batch of 32
        bus_if.start = 1'b1; bus_if.num_words = 6'd32;
        tick();
        chk("full_busy0", 64'(bus_if.busy), 64'd1);
        bus_if.start = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 32; k++) begin
            d = 16'(k * 3 - 50);
            bus_if.in_data = d;
            #1;
            chk($sformatf("full_ready%0d", k), 64'(bus_if.in_ready), 64'd1);
            tick();
            chk($sformatf("full_we%0d", k),   64'(bus_if.lane_we),  64'(32'h1 << k));
            chk($sformatf("full_sel%0d", k),  64'(bus_if.sel_out),  64'(k));
            chk($sformatf("full_data%0d", k), 64'(bus_if.data_out), 64'(d));
            chk($sformatf("full_done%0d", k), 64'(bus_if.done),     64'(k == 31));
        end
        chk("full_busy_done", 64'(bus_if.busy), 64'd1);
        chk("full_ready_done", 64'(bus_if.in_ready), 64'd0);
        tick();
        chk_idle_outputs("full_end");
        chk("full_sel_hold", 64'(bus_if.sel_out), 64'd31);
        bus_if.in_valid = 1'b0;

        // 3. backpressure, num_words=4
        bus_if.start = 1'b1; bus_if.num_words = 6'd4;
        tick();
        bus_if.start = 1'b0;
        chk("bp_we_start", 64'(bus_if.lane_we), 64'd0);
        for (int i = 0; i < 7; i++) begin
            bus_if.in_valid = bp_valid[i];
            bus_if.in_data  = 16'h1000 + 16'(i);
            tick();
            chk($sformatf("bp_we%0d", i),   64'(bus_if.lane_we),  64'(bp_we[i]));
            chk($sformatf("bp_sel%0d", i),  64'(bus_if.sel_out),  64'(bp_sel[i]));
            chk($sformatf("bp_data%0d", i), 64'(bus_if.data_out), 64'(bp_data[i]));
            chk($sformatf("bp_done%0d", i), 64'(bus_if.done),     64'(bp_done[i]));
        end
        bus_if.in_valid = 1'b0;
        tick();
        chk_idle_outputs("bp_end");

        // 4. illegal word counts
        bus_if.start = 1'b1; bus_if.num_words = 6'd0;
        tick();
        bus_if.start = 1'b0;
        chk("ill0_err",  64'(bus_if.err),     64'd1);
        chk("ill0_busy", 64'(bus_if.busy),    64'd0);
        chk("ill0_we",   64'(bus_if.lane_we), 64'd0);
        tick();
        chk("ill0_err_clr", 64'(bus_if.err), 64'd0);
        bus_if.start = 1'b1; bus_if.num_words = 6'd33;
        tick();
        bus_if.start = 1'b0;
        chk("ill33_err",  64'(bus_if.err),     64'd1);
        chk("ill33_busy", 64'(bus_if.busy),    64'd0);
        chk("ill33_we",   64'(bus_if.lane_we), 64'd0);
        tick();
        chk_idle_outputs("ill_end");

        // 5. abort on third valid cycle
        bus_if.start = 1'b1; bus_if.num_words = 6'd8;
        tick();
        bus_if.start = 1'b0;
        bus_if.in_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            bus_if.in_data = 16'h0A00 + 16'(k);
            tick();
            chk($sformatf("ab_we%0d", k), 64'(bus_if.lane_we), 64'(32'h1 << k));
        end
        bus_if.in_data = 16'h0A02;
        bus_if.abort = 1'b1;
        #1;
        chk("ab_ready", 64'(bus_if.in_ready), 64'd0);
        tick();
        bus_if.abort = 1'b0;
        bus_if.in_valid = 1'b0;
        chk_idle_outputs("ab_idle");
        chk("ab_sel_hold",  64'(bus_if.sel_out),  64'd1);
        chk("ab_data_hold", 64'(bus_if.data_out), 64'h0A01);
        bus_if.start = 1'b1; bus_if.num_words = 6'd1;
        tick();
        bus_if.start = 1'b0;
        chk("ab_restart_busy", 64'(bus_if.busy), 64'd1);
        bus_if.in_valid = 1'b1; bus_if.in_data = 16'h7FFF;
        tick();
        bus_if.in_valid = 1'b0;
        chk("ab_one_we",   64'(bus_if.lane_we),  64'd1);
        chk("ab_one_done", 64'(bus_if.done),     64'd1);
        chk("ab_one_data", 64'(bus_if.data_out), 64'h7FFF);
        tick();
        chk_idle_outputs("ab_end");

        // 6. start while busy is ignored
        bus_if.start = 1'b1; bus_if.num_words = 6'd5;
        tick();
        bus_if.start = 1'b0;
        bus_if.in_valid = 1'b1;
        writes = 0;
        dones  = 0;
        for (int c = 0; c < 10; c++) begin
            bus_if.in_data = 16'(c);
            if (c == 2) begin
                bus_if.start = 1'b1; bus_if.num_words = 6'd3;
            end else begin
                bus_if.start = 1'b0;
            end
            tick();
            writes += $countones(bus_if.lane_we);
            dones  += int'(bus_if.done);
        end
        bus_if.start = 1'b0;
        bus_if.in_valid = 1'b0;
        chk("sb_writes", 64'(writes), 64'd5);
        chk("sb_dones",  64'(dones),  64'd1);
        chk("sb_busy",   64'(bus_if.busy), 64'd0);
        chk("sb_sel",    64'(bus_if.sel_out), 64'd4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
